i2c_target: RTL
===============

Name: i2c_target

Overview:
- Byte-level I2C target (slave) engine; the bus-side counterpart of the team's byte-level I2C controller.
- Oversamples SCL/SDA on the system clock, detects START/STOP and matches a 7-bit address.
- Delivers received bytes to user logic and requests bytes for read transfers. Drives SDA open-drain only; never drives SCL (no clock stretching).

Parameters:
- DEV_ADDR, 7'h50, 7-bit target address compared against the first byte after START.
- FILTER_LEN, 3, synchronized samples that must agree before the filtered SCL/SDA level changes (range 1..7).

Ports:
- clk  in  1  system clock; must be >= 20x the SCL frequency.
- rst  in  1  synchronous, active-high reset.
- iic_sda  inout  1  open-drain SDA: drive 0 or Z.
- iic_scl  inout  1  SCL; input only, always Z.
- rx_data  out  8  last byte written by the controller; valid when rx_valid=1.
- rx_valid  out  1  one-cycle pulse, data byte received.
- tx_data  in  8  byte to return on a read; sampled in the cycle tx_load=1.
- tx_load  out  1  one-cycle pulse, block captures tx_data this cycle.
- rw  out  1  R/W bit of the current matched address: 1 = read.
- start_det  out  1  one-cycle pulse on START or repeated START.
- stop_det  out  1  one-cycle pulse on STOP.
- busy  out  1  high from an address match until STOP, a NACKed read, or reset.

Behaviour:
- Input path: 2-FF synchronizer per line, then filter. The filtered level changes only when FILTER_LEN consecutive synced samples agree. Filter reset value = 1.
- Edge detection on filtered signals:
  - SCL rise/fall = one-cycle strobes.
  - START = SDA fall while SCL high.
  - STOP = SDA rise while SCL high.
  - START/STOP take priority over any state.
- Reset: state IDLE, SDA released, bit counter 0. All outputs 0, rx_data=8'h00.
- States: IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, WAIT_STOP.
- START (any state): start_det=1, bit cnt=7, SDA released, state=ADDR. busy drops to 0 until the next match.
- STOP (any state): stop_det=1, SDA released, busy=0, state=IDLE.
- ADDR:
  - Shift SDA MSB-first on each SCL rise.
  - After the 8th rise, compare [7:1] with DEV_ADDR.
  - Match: rw<=bit0, busy<=1, state=ADDR_ACK.
  - Mismatch: state=WAIT_STOP; SDA is never driven.
- ADDR_ACK:
  - On the next SCL fall, drive SDA=0.
  - If rw=1, pulse tx_load in that same cycle and capture tx_data into the shift register.
  - On the following SCL fall, release SDA (rw=0) or drive bit7 of the shift register (rw=1).
  - Then go to WR_BYTE or RD_BYTE.
- WR_BYTE:
  - Sample on SCL rises.
  - On the 8th rise, rx_data<=byte and rx_valid pulse in the same cycle. Go to WR_ACK.
- WR_ACK: drive SDA=0 on the next SCL fall, release on the following fall, return to WR_BYTE. Every byte is ACKed.
- RD_BYTE:
  - SDA changes only on SCL fall edges (bit7 first). A 1 bit = release.
  - After the 8th bit's SCL fall, release SDA and go to RD_ACK.
- RD_ACK:
  - Sample SDA on the SCL rise.
  - ACK (0): pulse tx_load in that cycle and capture tx_data. Drive the new bit7 on the next SCL fall, go to RD_BYTE.
  - NACK (1): busy=0, state=WAIT_STOP.
- WAIT_STOP: ignore SCL edges; exit only on START/STOP.
- Hold time: SDA updates occur sync+filter latency (2+FILTER_LEN clocks) after the true SCL fall.
- A repeated START mid-byte discards the partial byte; no rx_valid.
- Reset asserted mid-transfer releases SDA in the next cycle.

Optional Feature:
- I2C_TARGET_GCALL_EN.
- Defined: address byte 8'h00 (general call, write) is also matched and ACKed. The following bytes go through WR_BYTE/WR_ACK exactly as for DEV_ADDR, with rw=0.
- Undefined: 8'h00 is treated as a mismatch, no ACK, state=WAIT_STOP.
- Address byte 8'h01 is never matched in either build.

Test Plan:
- Write: START, 8'hA0, 8'h3C, 8'hC3, STOP.
  - SDA=0 during all 3 ACK clocks.
  - rx_valid pulses twice, with rx_data=3C then C3.
  - start_det=1 once, stop_det=1 once, busy 1->0 at STOP.
- Read: START, 8'hA1, controller ACKs byte 1 and NACKs byte 2; tx_data=8'h5A then 8'hF0.
  - Bus carries 5A, F0.
  - tx_load pulses exactly 2 times.
  - SDA released after the NACK; busy=0.
- Mismatch: START, 8'hA2.
  - SDA never 0 for the rest of the transfer.
  - No rx_valid, busy=0; a following STOP gives stop_det=1.
- Repeated START: write 8'hA0, 4 bits of data, START, 8'hA1.
  - No rx_valid for the partial byte; rw=1.
  - tx_load pulses at the address ACK.
- Glitch: with SCL high, a 2-clk SDA low pulse (FILTER_LEN=3) gives no start_det. A 4-clk pulse gives start_det=1.
- Reset mid-read: assert rst during bit 4 of a read byte.
  - SDA released the next cycle, state IDLE.
  - A new START then 8'hA0 is ACKed normally.

Source files
------------

// File: rtl/i2c_target.sv
// i2c_target: byte-level I2C target engine. Oversamples SCL/SDA on clk, detects START/STOP,
// matches a 7-bit address, hands received bytes to user logic and fetches bytes for reads.
// SDA is driven open-drain (0 or Z); SCL is never driven, so there is no clock stretching.
// Optional build macro: I2C_TARGET_GCALL_EN also accepts the general-call address byte 8'h00.
module i2c_target #(
    parameter logic [6:0]  DEV_ADDR   = 7'h50,
    parameter int unsigned FILTER_LEN = 3
) (
    input  logic       clk,
    input  logic       rst,
    inout  wire        iic_sda,
    inout  wire        iic_scl,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_load,
    output logic       rw,
    output logic       start_det,
    output logic       stop_det,
    output logic       busy
);

    typedef enum logic [2:0] {
        StIdle, StAddr, StAddrAck, StWrByte, StWrAck, StRdByte, StRdAck, StWaitStop
    } state_e;

    // Bit 0 = SCL, bit 1 = SDA throughout the input path.
    logic [1:0]      raw;
    logic [1:0]      sync1_q, sync2_q, filt_q, filt_prev_q;
    logic [1:0][2:0] fcnt_q;

    state_e      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  rx_data_q, rx_data_d;
    logic        rx_valid_q, rx_valid_d;
    logic        sda_oe_q, sda_oe_d;
    logic        ack_q, ack_d;          // first ACK-phase edge already handled
    logic        rw_q, rw_d;
    logic        busy_q, busy_d;
    logic        tx_load_c;

    logic        scl_f, sda_f, scl_rise, scl_fall, start_s, stop_s, addr_match;
    logic [7:0]  rx_byte;

    assign raw = {iic_sda, iic_scl};

    // Two-flop synchronizer plus agreement filter: level flips after FILTER_LEN differing samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q     <= 2'b11;
            sync2_q     <= 2'b11;
            filt_q      <= 2'b11;
            filt_prev_q <= 2'b11;
            fcnt_q      <= '0;
        end else begin
            sync1_q     <= raw;
            sync2_q     <= sync1_q;
            filt_prev_q <= filt_q;
            for (int i = 0; i < 2; i++) begin
                if (sync2_q[i] == filt_q[i]) begin
                    fcnt_q[i] <= 3'd0;
                end else if (fcnt_q[i] == 3'(FILTER_LEN - 1)) begin
                    filt_q[i] <= sync2_q[i];
                    fcnt_q[i] <= 3'd0;
                end else begin
                    fcnt_q[i] <= fcnt_q[i] + 3'd1;
                end
            end
        end
    end

    assign scl_f    = filt_q[0];
    assign sda_f    = filt_q[1];
    assign scl_rise = scl_f & ~filt_prev_q[0];
    assign scl_fall = ~scl_f & filt_prev_q[0];
    assign start_s  = filt_prev_q[1] & ~sda_f & scl_f & filt_prev_q[0];
    assign stop_s   = ~filt_prev_q[1] & sda_f & scl_f & filt_prev_q[0];
    assign rx_byte  = {shift_q[6:0], sda_f};

`ifdef I2C_TARGET_GCALL_EN
    assign addr_match = (rx_byte[7:1] == DEV_ADDR) || (rx_byte == 8'h00);
`else
    assign addr_match = (rx_byte[7:1] == DEV_ADDR);
`endif

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            cnt_q      <= 3'd0;
            shift_q    <= 8'h00;
            rx_data_q  <= 8'h00;
            rx_valid_q <= 1'b0;
            sda_oe_q   <= 1'b0;
            ack_q      <= 1'b0;
            rw_q       <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            sda_oe_q   <= sda_oe_d;
            ack_q      <= ack_d;
            rw_q       <= rw_d;
            busy_q     <= busy_d;
        end
    end

    // Next-state logic; START/STOP override every state.
    always_comb begin
        state_d = state_q;
        if (start_s) begin
            state_d = StAddr;
        end else if (stop_s) begin
            state_d = StIdle;
        end else begin
            case (state_q)
                StAddr:    if (scl_rise && cnt_q == 3'd0)
                               state_d = addr_match ? StAddrAck : StWaitStop;
                StAddrAck: if (scl_fall && ack_q) state_d = rw_q ? StRdByte : StWrByte;
                StWrByte:  if (scl_rise && cnt_q == 3'd0) state_d = StWrAck;
                StWrAck:   if (scl_fall && ack_q) state_d = StWrByte;
                StRdByte:  if (scl_fall && cnt_q == 3'd0) state_d = StRdAck;
                StRdAck: begin
                    if (scl_rise && !ack_q && sda_f) state_d = StWaitStop;
                    else if (scl_fall && ack_q)      state_d = StRdByte;
                end
                default:   state_d = state_q;
            endcase
        end
    end

    // Datapath next values and bus/handshake outputs per state.
    always_comb begin
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        sda_oe_d   = sda_oe_q;
        ack_d      = ack_q;
        rw_d       = rw_q;
        busy_d     = busy_q;
        tx_load_c  = 1'b0;
        if (start_s) begin
            cnt_d    = 3'd7;
            sda_oe_d = 1'b0;
            ack_d    = 1'b0;
            busy_d   = 1'b0;
        end else if (stop_s) begin
            sda_oe_d = 1'b0;
            ack_d    = 1'b0;
            busy_d   = 1'b0;
        end else begin
            case (state_q)
                StAddr: if (scl_rise) begin
                    shift_d = rx_byte;
                    if (cnt_q == 3'd0) begin
                        ack_d = 1'b0;
                        if (addr_match) begin
                            rw_d   = rx_byte[0];
                            busy_d = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q - 3'd1;
                    end
                end
                StAddrAck: if (scl_fall) begin
                    if (!ack_q) begin
                        sda_oe_d = 1'b1;
                        ack_d    = 1'b1;
                        if (rw_q) begin
                            tx_load_c = 1'b1;
                            shift_d   = tx_data;
                        end
                    end else begin
                        cnt_d    = 3'd7;
                        ack_d    = 1'b0;
                        sda_oe_d = rw_q ? ~shift_q[7] : 1'b0;
                    end
                end
                StWrByte: if (scl_rise) begin
                    shift_d = rx_byte;
                    if (cnt_q == 3'd0) begin
                        rx_data_d  = rx_byte;
                        rx_valid_d = 1'b1;
                        ack_d      = 1'b0;
                    end else begin
                        cnt_d = cnt_q - 3'd1;
                    end
                end
                StWrAck: if (scl_fall) begin
                    if (!ack_q) begin
                        sda_oe_d = 1'b1;
                        ack_d    = 1'b1;
                    end else begin
                        sda_oe_d = 1'b0;
                        ack_d    = 1'b0;
                        cnt_d    = 3'd7;
                    end
                end
                StRdByte: if (scl_fall) begin
                    if (cnt_q == 3'd0) begin
                        sda_oe_d = 1'b0;
                        ack_d    = 1'b0;
                    end else begin
                        cnt_d    = cnt_q - 3'd1;
                        shift_d  = {shift_q[6:0], 1'b0};
                        sda_oe_d = ~shift_q[6];
                    end
                end
                StRdAck: begin
                    if (scl_rise && !ack_q) begin
                        if (sda_f) begin
                            busy_d = 1'b0;
                        end else begin
                            tx_load_c = 1'b1;
                            shift_d   = tx_data;
                            ack_d     = 1'b1;
                        end
                    end else if (scl_fall && ack_q) begin
                        sda_oe_d = ~shift_q[7];
                        cnt_d    = 3'd7;
                        ack_d    = 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign iic_sda   = sda_oe_q ? 1'b0 : 1'bz;
    assign iic_scl   = 1'bz;
    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign rw        = rw_q;
    assign busy      = busy_q;
    // Strobes come straight from the filter stage; mask them in the reset cycle itself.
    assign tx_load   = tx_load_c & ~rst;
    assign start_det = start_s & ~rst;
    assign stop_det  = stop_s & ~rst;

endmodule
